key_debounce_tx: RTL and testbench
==================================

Name: key_debounce_tx

Overview:
- Per-key front end that turns raw, bouncing, active-low board buttons into clean signals for the game logic.
- Outputs per key: a debounced active-low level (idle 1, pressed 0), which is what the pause/continue controller edge-detects; one-cycle press and release strobes; and a hold/auto-repeat strobe for menu navigation.
- Sits between the pad inputs and game_controller and the other key consumers.

Parameters:
NUM_KEYS, 5, number of independent buttons
DEBOUNCE_CYCLES, 1000000, cycles the synchronized input must stay stable before a change is accepted (20 ms at 50 MHz); must be >= 2
LONG_CYCLES, 25000000, cycles of accepted press before the first hold strobe; must be >= 1
REPEAT_CYCLES, 5000000, cycles between subsequent hold strobes; must be >= 1
CNT_W, 25, counter width; must hold max(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES)

Ports:
clk  input  1  system clock; the only clock
rst  input  1  synchronous, active-high reset
key_raw_n  input  NUM_KEYS  raw buttons, active-low, asynchronous to clk
key_level_n  output  NUM_KEYS  debounced level, active-low (1 = released)
key_press  output  NUM_KEYS  one-cycle strobe when a press is accepted
key_release  output  NUM_KEYS  one-cycle strobe when a release is accepted
key_hold  output  NUM_KEYS  one-cycle strobe for long press and auto-repeat
any_press  output  1  OR of key_press

Behaviour:
- Reset (rst=1 at a clk edge):
  - Synchronizer flops go to 1.
  - All FSMs go to IDLE; counters go to 0.
  - key_level_n resets to all 1s; key_press, key_release, key_hold and any_press reset to 0.
  - Reset mid-debounce or mid-hold abandons the operation and emits no strobe.
- Synchronizer: two flops per key. The FSM acts only on the second-stage value s.
- Per-key FSM with states IDLE, DB_PRESS, PRESSED, DB_RELEASE. Each key has its own debounce counter dcnt and hold counter hcnt.
  - IDLE (level 1): if s=0, go to DB_PRESS with dcnt=0.
  - DB_PRESS:
    - s=1: return to IDLE with no strobe (this is bounce rejection).
    - s=0 and dcnt=DEBOUNCE_CYCLES-1: go to PRESSED, key_level_n<=0, key_press=1 for one cycle, hcnt=0.
    - otherwise: dcnt++.
  - PRESSED:
    - s=1: go to DB_RELEASE with dcnt=0; hcnt is frozen.
    - otherwise hcnt++. A key_hold pulse fires when hcnt reaches LONG_CYCLES-1 the first time, then every REPEAT_CYCLES cycles (hcnt reloads to LONG_CYCLES-REPEAT_CYCLES, or an equivalent scheme).
  - DB_RELEASE:
    - s=0: return to PRESSED; hold timing resumes from the frozen hcnt and no strobe is emitted.
    - s=1 and dcnt=DEBOUNCE_CYCLES-1: go to IDLE, key_level_n<=1, key_release=1 for one cycle.
    - otherwise: dcnt++.
- Latency:
  - If raw is first sampled low at edge k and stays low, key_level_n falls and key_press asserts at edge k+DEBOUNCE_CYCLES+2 (2 synchronizer edges, 1 FSM entry edge, then DEBOUNCE_CYCLES-1 counted edges).
  - Release latency is the same.
  - The first key_hold is LONG_CYCLES edges after key_press, and then every REPEAT_CYCLES edges.
- Strobe rules:
  - All outputs are registered; strobes are exactly one cycle wide.
  - key_press and key_release never assert in the same cycle for the same key.
  - key_hold only asserts while key_level_n=0.
  - Keys are fully independent; simultaneous presses on several keys give simultaneous strobes.
  - any_press is registered in the same cycle as key_press.
- Counters saturate safely: hcnt never wraps into a spurious strobe.

Test Plan:
Use DEBOUNCE_CYCLES=4, LONG_CYCLES=10, REPEAT_CYCLES=3, NUM_KEYS=2 throughout.
- Clean press: key_raw_n[0] goes from 1 to 0 sampled at edge k -> key_level_n[0]=0 and key_press[0]=1 at edge k+6 only, and any_press=1 in the same cycle.
- Bounce reject: raw[0] low for 3 cycles, high for 1, then low -> no press before the final stable run. The press is accepted 6 edges after the last falling sample.
- Hold/repeat: press accepted at edge p and held for 20 cycles -> key_hold[0] at p+10, p+13, p+16, p+19, and never while released.
- Release glitch: held key, raw high for 2 cycles then low -> no key_release, key_level_n stays 0, and hold cadence continues. A sustained release gives key_release 6 edges after the first high sample.
- Simultaneous keys: both raw bits fall on the same edge -> key_press=2'b11 on the same cycle; release key1 only -> key_release=2'b10 with key0 unaffected.
- Reset mid-hold: rst=1 for 1 cycle while key0 is in PRESSED -> next edge key_level_n=2'b11 and all strobes are 0. With raw still low, a re-press is accepted 6 edges after rst deasserts.

Source files
------------

// File: rtl/key_debounce_tx.sv
// key_debounce_tx: per-key front end for raw active-low board buttons.
// Each key gets a two-flop synchronizer and a small FSM that debounces
// press and release. The FSM produces a clean active-low level, one-cycle
// press/release strobes and a long-press / auto-repeat hold strobe.
module key_debounce_tx #(
  parameter int NUM_KEYS        = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_raw_n,
  output logic [NUM_KEYS-1:0] key_level_n,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_hold,
  output logic                any_press
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } key_state_t;

  // Terminal counts. Each counter runs 0..N-1, so the last value is N-1.
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync_q1;
  logic [NUM_KEYS-1:0] sync_q2;
  logic [NUM_KEYS-1:0] press_nx;

  // Two-flop synchronizer. It idles high so that reset looks like "released".
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= key_raw_n;
      sync_q2 <= sync_q1;
    end
  end

  // any_press is registered alongside key_press, from the same next-state bits.
  always_ff @(posedge clk) begin
    if (rst) any_press <= 1'b0;
    else     any_press <= |press_nx;
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_state_t       state_q, state_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic             rep_q, rep_d;      // 0: waiting for the long press, 1: repeating
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             hold_q, hold_d;
    logic             s;
    logic [CNT_W-1:0] hold_last;

    assign s         = sync_q2[g];
    assign hold_last = rep_q ? REP_LAST : LONG_LAST;

    // State, counters and registered outputs for this key.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q   <= IDLE;
        dcnt_q    <= '0;
        hcnt_q    <= '0;
        rep_q     <= 1'b0;
        level_q   <= 1'b1;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        hold_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        dcnt_q    <= dcnt_d;
        hcnt_q    <= hcnt_d;
        rep_q     <= rep_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        hold_q    <= hold_d;
      end
    end

    // Next-state logic: debounce both edges and pace the hold strobes.
    // NOTE: every always_comb output gets a default first so that no path infers a latch.
    always_comb begin
      state_d   = state_q;
      dcnt_d    = dcnt_q;
      hcnt_d    = hcnt_q;
      rep_d     = rep_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      hold_d    = 1'b0;
      case (state_q)
        IDLE: begin
          if (!s) begin
            state_d = DB_PRESS;
            dcnt_d  = '0;
          end
        end
        DB_PRESS: begin
          if (s) begin
            state_d = IDLE;                 // bounce: drop back silently
          end else if (dcnt_q == DB_LAST) begin
            state_d = PRESSED;
            level_d = 1'b0;
            press_d = 1'b1;
            hcnt_d  = '0;
            rep_d   = 1'b0;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (s) begin
            state_d = DB_RELEASE;           // hcnt frozen while release is debounced
            dcnt_d  = '0;
          end else if (hcnt_q >= hold_last) begin
            // Restarting from 0 keeps hcnt bounded, so it can never wrap.
            hold_d = 1'b1;
            hcnt_d = '0;
            rep_d  = 1'b1;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        DB_RELEASE: begin
          if (!s) begin
            state_d = PRESSED;              // glitch: resume hold timing as is
          end else if (dcnt_q == DB_LAST) begin
            state_d   = IDLE;
            level_d   = 1'b1;
            release_d = 1'b1;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    assign key_level_n[g] = level_q;
    assign key_press[g]   = press_q;
    assign key_release[g] = release_q;
    assign key_hold[g]    = hold_q;
    assign press_nx[g]    = press_d;
  end

endmodule

// File: tb/tb_key_debounce_tx.sv
// Testbench for key_debounce_tx. Directed scenarios are followed by a
// randomized phase. Every cycle is compared against a behavioural model
// built on run lengths of the synchronized input and a count of held cycles.
module tb_key_debounce_tx;

  localparam int N = 2;
  localparam int D = 4;
  localparam int L = 10;
  localparam int R = 3;

  logic         clk;
  logic         rst;
  logic [N-1:0] key_raw_n;
  logic [N-1:0] key_level_n, key_press, key_release, key_hold;
  logic         any_press;

  int total = 0;
  int bad   = 0;

  key_debounce_tx #(
    .NUM_KEYS(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L),
    .REPEAT_CYCLES(R), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .key_raw_n(key_raw_n),
    .key_level_n(key_level_n), .key_press(key_press),
    .key_release(key_release), .key_hold(key_hold), .any_press(any_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [N-1:0] m_s1, m_s2, m_level, m_press, m_rel, m_hold;
  logic         m_any;
  int           m_run [N];   // consecutive samples that disagree with the level
  int           m_age [N];   // held cycles since the press was accepted

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the model, using the inputs that were present at the edge.
  // A change is accepted after D+1 consecutive opposing synchronized samples.
  // Hold strobes fire at held ages L, L+R, L+2R, ...
  task automatic model_edge();
    if (rst) begin
      m_s1 = '1; m_s2 = '1; m_level = '1;
      m_press = '0; m_rel = '0; m_hold = '0; m_any = 1'b0;
      for (int i = 0; i < N; i++) begin m_run[i] = 0; m_age[i] = 0; end
    end else begin
      m_press = '0; m_rel = '0; m_hold = '0;
      for (int i = 0; i < N; i++) begin
        if (m_s2[i] != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == D + 1) begin
            m_level[i] = m_s2[i];
            m_run[i]   = 0;
            if (!m_s2[i]) begin m_press[i] = 1'b1; m_age[i] = 0; end
            else          m_rel[i] = 1'b1;
          end
        end else begin
          if (!m_level[i] && m_run[i] == 0) begin
            m_age[i]++;
            if (m_age[i] == L || (m_age[i] > L && (m_age[i] - L) % R == 0))
              m_hold[i] = 1'b1;
          end
          m_run[i] = 0;
        end
      end
      m_any = |m_press;
      m_s2  = m_s1;
      m_s1  = key_raw_n;
    end
  endtask

  // Drive the inputs, take one edge, then compare on the falling edge.
  task automatic step(input logic [N-1:0] raw, input logic r);
    key_raw_n = raw;
    rst       = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("level",   key_level_n, m_level);
    check("press",   key_press,   m_press);
    check("release", key_release, m_rel);
    check("hold",    key_hold,    m_hold);
    check("any",     any_press,   m_any);
  endtask

  // Hold raw steady and return the number of edges from the first sample to
  // the watched strobe (sel 0: press, 1: release), or -1 if it never comes.
  task automatic watch(input logic [N-1:0] raw, input int sel, input int idx, output int edges);
    edges = -1;
    for (int n = 1; n <= 40; n++) begin
      step(raw, 1'b0);
      if ((sel == 0 ? key_press[idx] : key_release[idx]) === 1'b1) begin
        edges = n - 1;
        break;
      end
    end
  endtask

  initial begin
    int          e;
    logic [31:0] holds;
    logic        seen;
    logic [N-1:0] rv;
    int          left [N];
    int unsigned r;

    key_raw_n = '1;
    rst       = 1'b1;

    // Reset state.
    step(2'b11, 1'b1);
    step(2'b11, 1'b1);
    check("rst_level", key_level_n, 2'b11);
    check("rst_strobes", {key_press, key_release, key_hold, any_press}, 0);
    repeat (3) step(2'b11, 1'b0);

    // Clean press on key 0.
    watch(2'b10, 0, 0, e);
    check("press_lat", e, 6);
    check("press_any", any_press, 1);
    check("press_level", key_level_n, 2'b10);

    // Hold and repeat cadence while key 0 stays down.
    holds = '0;
    for (int j = 1; j <= 20; j++) begin
      step(2'b10, 1'b0);
      if (key_hold[0]) holds[j] = 1'b1;
    end
    check("hold_cadence", holds, (32'd1 << 10) | (32'd1 << 13) | (32'd1 << 16) | (32'd1 << 19));

    // A short release glitch must not release the key.
    seen = 1'b0;
    step(2'b11, 1'b0); seen |= key_release[0];
    step(2'b11, 1'b0); seen |= key_release[0];
    for (int j = 0; j < 4; j++) begin step(2'b10, 1'b0); seen |= key_release[0]; end
    check("glitch_norel", seen, 0);
    check("glitch_level", key_level_n[0], 0);
    watch(2'b11, 1, 0, e);
    check("release_lat", e, 6);

    // Bounce rejection: 3 low, 1 high, then a stable low run.
    repeat (4) step(2'b11, 1'b0);
    seen = 1'b0;
    for (int j = 0; j < 3; j++) begin step(2'b10, 1'b0); seen |= key_press[0]; end
    step(2'b11, 1'b0); seen |= key_press[0];
    check("bounce_nopress", seen, 0);
    watch(2'b10, 0, 0, e);
    check("bounce_lat", e, 6);

    // Simultaneous press, then release of key 1 only.
    repeat (10) step(2'b11, 1'b0);
    watch(2'b00, 0, 0, e);
    check("simul_press", key_press, 2'b11);
    check("simul_any", any_press, 1);
    watch(2'b10, 1, 1, e);
    check("rel_k1", key_release, 2'b10);
    check("rel_k1_k0level", key_level_n[0], 0);

    // Reset while key 0 is held, then re-press with raw still low.
    repeat (3) step(2'b10, 1'b0);
    step(2'b10, 1'b1);
    check("midrst_level", key_level_n, 2'b11);
    check("midrst_strobes", {key_press, key_release, key_hold, any_press}, 0);
    watch(2'b10, 0, 0, e);
    check("repress_lat", e, 6);

    // Randomized phase: run lengths are a mix of bounce, mid-length and long holds.
    rv = key_raw_n;
    for (int i = 0; i < N; i++) left[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (left[i] == 0) begin
          rv[i] = ~rv[i];
          r = $urandom_range(0, 9);
          if (r < 4)      left[i] = $urandom_range(1, 3);
          else if (r < 8) left[i] = $urandom_range(4, 12);
          else            left[i] = $urandom_range(13, 40);
        end
        left[i]--;
      end
      step(rv, ($urandom_range(0, 499) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
